// File: rtl/boton_pkg.sv
// Shared definitions for the button event arbiter: press FSM encoding,
// event type codes and the default number of buttons.
package boton_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_HELD    = 2'd2
   } press_state_e;

   localparam logic EVT_SHORT     = 1'b0;
   localparam logic EVT_LONG      = 1'b1;
   localparam int   N_BOT_DEFAULT = 4;

endpackage

// File: rtl/boton_press_fsm.sv
// Per-button press classifier: edge detect, saturating press counter and
// a short/long event pulse in the cycle the press is classified.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | button released, waiting for a rising edge
//   ST_PRESSED | button high, counting; release here is a short press
//   ST_HELD    | long press already reported, waiting for release
module boton_press_fsm
   import boton_pkg::*;
#(
   parameter int LONG_COUNT = 50000000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_i,
   output logic evt_o,
   output logic evt_long_o
);

   localparam int CW = $clog2(LONG_COUNT + 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_PRE = CW'(LONG_COUNT - 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(LONG_COUNT);

   press_state_e  state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          prev_q;
   logic          rise;

   // Previous level resets high so a button held through reset is ignored
   assign rise = btn_i & ~prev_q;

   // State, counter and previous-level registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         prev_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prev_q  <= btn_i;
      end
   end

   // Next state and counter; the counter jumps to LONG_COUNT and holds there
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (rise) begin
               state_d = ST_PRESSED;
               cnt_d   = CNT_ONE;
            end
         end
         ST_PRESSED: begin
            if (!btn_i) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_PRE) begin
               state_d = ST_HELD;
               cnt_d   = CNT_MAX;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_HELD: begin
            if (!btn_i) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Event pulse in the cycle the press is classified
   always_comb begin
      evt_o      = 1'b0;
      evt_long_o = EVT_SHORT;
      if (state_q == ST_PRESSED) begin
         if (!btn_i) begin
            evt_o      = 1'b1;
            evt_long_o = EVT_SHORT;
         end else if (cnt_q == CNT_PRE) begin
            evt_o      = 1'b1;
            evt_long_o = EVT_LONG;
         end
      end
   end

endmodule

// File: rtl/boton_arbiter.sv
// Collects short/long press events from N_BOT buttons into one pending slot
// per button and hands them out round-robin through a valid/ready register.
module boton_arbiter
   import boton_pkg::*;
#(
   parameter int N_BOT      = N_BOT_DEFAULT,
   parameter int LONG_COUNT = 50000000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_BOT-1:0]         boton_in,
   output logic                     evt_valid,
   output logic [$clog2(N_BOT)-1:0] evt_id,
   output logic                     evt_long,
   input  logic                     evt_ready,
   output logic [N_BOT-1:0]         overflow,
   input  logic                     clr_overflow
);

   localparam int ID_W = $clog2(N_BOT);

   logic [N_BOT-1:0] raise, raise_long;
   logic [N_BOT-1:0] pend_q, pend_d;
   logic [N_BOT-1:0] type_q, type_d;
   logic [N_BOT-1:0] ovf_q, ovf_d;
   logic [N_BOT-1:0] gnt;
   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic [ID_W-1:0]  pick_id;
   logic             pick_vld;
   logic             load;
   logic             valid_q, valid_d;
   logic [ID_W-1:0]  id_q, id_d;
   logic             long_q, long_d;

   generate
      for (genvar i = 0; i < N_BOT; i++) begin : g_btn
         boton_press_fsm #(.LONG_COUNT(LONG_COUNT)) u_fsm (
            .clk        (clk),
            .reset      (reset),
            .btn_i      (boton_in[i]),
            .evt_o      (raise[i]),
            .evt_long_o (raise_long[i])
         );
      end
   endgenerate

   // Round-robin search over pending bits starting at the pointer
   always_comb begin : p_pick
      int idx;
      idx      = 0;
      pick_vld = 1'b0;
      pick_id  = '0;
      for (int k = 0; k < N_BOT; k++) begin
         idx = (int'(ptr_q) + k) % N_BOT;
         if (!pick_vld && pend_q[idx]) begin
            pick_vld = 1'b1;
            pick_id  = ID_W'(idx);
         end
      end
   end

   // The output register accepts a new event when empty or being drained
   assign load = pick_vld & (~valid_q | evt_ready);

   // Pending/overflow bookkeeping, pointer advance and output register next state
   always_comb begin
      gnt = '0;
      if (load) gnt[pick_id] = 1'b1;
      // A raise on a slot that is being granted this cycle refills it
      pend_d = (pend_q & ~gnt) | raise;
      type_d = type_q;
      for (int i = 0; i < N_BOT; i++) begin
         if (raise[i] && (!pend_q[i] || gnt[i])) type_d[i] = raise_long[i];
      end
      // A new drop wins over a simultaneous clear on the same bit
      ovf_d = (clr_overflow ? '0 : ovf_q) | (raise & pend_q & ~gnt);

      ptr_d = ptr_q;
      if (load) ptr_d = (int'(pick_id) == N_BOT - 1) ? '0 : pick_id + ID_W'(1);

      valid_d = valid_q;
      id_d    = id_q;
      long_d  = long_q;
      if (load) begin
         valid_d = 1'b1;
         id_d    = pick_id;
         long_d  = type_q[pick_id];
      end else if (valid_q && evt_ready) begin
         valid_d = 1'b0;
      end
   end

   // Arbiter and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_q  <= '0;
         type_q  <= '0;
         ovf_q   <= '0;
         ptr_q   <= '0;
         valid_q <= 1'b0;
         id_q    <= '0;
         long_q  <= EVT_SHORT;
      end else begin
         pend_q  <= pend_d;
         type_q  <= type_d;
         ovf_q   <= ovf_d;
         ptr_q   <= ptr_d;
         valid_q <= valid_d;
         id_q    <= id_d;
         long_q  <= long_d;
      end
   end

   assign evt_valid = valid_q;
   assign evt_id    = id_q;
   assign evt_long  = long_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_boton_arbiter.sv
// Bench for boton_arbiter with N_BOT=4, LONG_COUNT=20: a press-counting
// event model checked every cycle, plus hand-computed literal checks.
module tb_boton_arbiter;

   localparam int N = 4;
   localparam int L = 20;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] boton_in = '0;
   logic         evt_ready = 1'b1;
   logic         clr_overflow = 1'b0;
   logic         evt_valid;
   logic [1:0]   evt_id;
   logic         evt_long;
   logic [N-1:0] overflow;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   boton_arbiter #(.N_BOT(N), .LONG_COUNT(L)) dut (
      .clk          (clk),
      .reset        (reset),
      .boton_in     (boton_in),
      .evt_valid    (evt_valid),
      .evt_id       (evt_id),
      .evt_long     (evt_long),
      .evt_ready    (evt_ready),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
   );

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: m_cnt = high cycles seen in the current press (0 idle, -1 long already reported)
   int m_cnt[N];
   bit m_prev[N];
   bit m_pend[N];
   bit m_type[N];
   bit m_ovf[N];
   int m_ptr;
   bit m_valid;
   int m_id;
   bit m_long;

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_cnt[i] = 0; m_prev[i] = 1'b1; m_pend[i] = 1'b0;
         m_type[i] = 1'b0; m_ovf[i] = 1'b0;
      end
      m_ptr = 0; m_valid = 1'b0; m_id = 0; m_long = 1'b0;
   endtask

   task automatic model_step();
      bit raise[N];
      bit rlong[N];
      bit b;
      int g;
      for (int i = 0; i < N; i++) begin
         raise[i] = 1'b0;
         rlong[i] = 1'b0;
         b = boton_in[i];
         if (m_cnt[i] == 0) begin
            if (b && !m_prev[i]) m_cnt[i] = 1;
         end else if (m_cnt[i] > 0) begin
            if (b) begin
               m_cnt[i]++;
               if (m_cnt[i] == L) begin
                  raise[i] = 1'b1; rlong[i] = 1'b1; m_cnt[i] = -1;
               end
            end else begin
               raise[i] = 1'b1; rlong[i] = 1'b0; m_cnt[i] = 0;
            end
         end else if (!b) begin
            m_cnt[i] = 0;
         end
         m_prev[i] = b;
      end
      g = -1;
      if (!m_valid || evt_ready) begin
         for (int k = 0; k < N; k++) begin
            if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
         end
      end
      if (g >= 0) begin
         m_valid = 1'b1; m_id = g; m_long = m_type[g];
         m_pend[g] = 1'b0; m_ptr = (g + 1) % N;
      end else if (m_valid && evt_ready) begin
         m_valid = 1'b0;
      end
      if (clr_overflow) for (int i = 0; i < N; i++) m_ovf[i] = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (raise[i]) begin
            if (m_pend[i]) m_ovf[i] = 1'b1;
            else begin
               m_pend[i] = 1'b1; m_type[i] = rlong[i];
            end
         end
      end
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) model_reset();
      else model_step();
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      int ovf_exp;
      ovf_exp = 0;
      for (int i = 0; i < N; i++) if (m_ovf[i]) ovf_exp |= (1 << i);
      chk("cmp_valid", int'(evt_valid), int'(m_valid));
      if (m_valid) begin
         chk("cmp_id", int'(evt_id), m_id);
         chk("cmp_long", int'(evt_long), int'(m_long));
      end
      chk("cmp_overflow", int'(overflow), ovf_exp);
   end

   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      cyc(3);
      reset = 1'b0;
      cyc(2);
      chk("rst_valid", int'(evt_valid), 0);
      chk("rst_ovf", int'(overflow), 0);

      // short press on button 2
      boton_in[2] = 1'b1; cyc(5); boton_in[2] = 1'b0;
      cyc(1); chk("short_lat1", int'(evt_valid), 0);
      cyc(1); chk("short_valid", int'(evt_valid), 1);
      chk("short_id", int'(evt_id), 2);
      chk("short_long", int'(evt_long), 0);
      cyc(1); chk("short_taken", int'(evt_valid), 0);

      // long press on button 1
      boton_in[1] = 1'b1; cyc(20); chk("long_early", int'(evt_valid), 0);
      cyc(1); chk("long_valid", int'(evt_valid), 1);
      chk("long_id", int'(evt_id), 1);
      chk("long_long", int'(evt_long), 1);
      cyc(9); boton_in[1] = 1'b0;
      cyc(4); chk("long_release", int'(evt_valid), 0);

      // fairness from pointer 0
      reset = 1'b1; cyc(1); reset = 1'b0; cyc(1);
      boton_in = 4'b1001; cyc(3); boton_in = '0;
      cyc(2); chk("rr0_first", int'(evt_id), 0); chk("rr0_v1", int'(evt_valid), 1);
      cyc(1); chk("rr0_second", int'(evt_id), 3); chk("rr0_v2", int'(evt_valid), 1);
      cyc(1); chk("rr0_done", int'(evt_valid), 0);
      // move pointer to 1, then repeat
      boton_in[0] = 1'b1; cyc(2); boton_in[0] = 1'b0; cyc(4);
      boton_in = 4'b1001; cyc(3); boton_in = '0;
      cyc(2); chk("rr1_first", int'(evt_id), 3);
      cyc(1); chk("rr1_second", int'(evt_id), 0);
      cyc(2);

      // backpressure and overflow on button 2
      evt_ready = 1'b0;
      boton_in[2] = 1'b1; cyc(3); boton_in[2] = 1'b0;
      cyc(2); chk("bp_valid", int'(evt_valid), 1); chk("bp_id", int'(evt_id), 2);
      boton_in[2] = 1'b1; cyc(4); boton_in[2] = 1'b0;
      cyc(2); chk("bp_no_ovf", int'(overflow), 0);
      boton_in[2] = 1'b1; cyc(25); boton_in[2] = 1'b0;
      cyc(2); chk("bp_ovf", int'(overflow), 4'b0100);
      chk("bp_hold_id", int'(evt_id), 2); chk("bp_hold_long", int'(evt_long), 0);
      cyc(20); chk("bp_stable_valid", int'(evt_valid), 1); chk("bp_stable_id", int'(evt_id), 2);
      evt_ready = 1'b1;
      cyc(1); chk("bp_next_valid", int'(evt_valid), 1);
      chk("bp_next_id", int'(evt_id), 2); chk("bp_next_long", int'(evt_long), 0);
      cyc(1); chk("bp_drained", int'(evt_valid), 0);

      // clear coincident with a new drop on button 1
      evt_ready = 1'b0;
      boton_in[1] = 1'b1; cyc(3); boton_in[1] = 1'b0; cyc(3);
      boton_in[1] = 1'b1; cyc(3); boton_in[1] = 1'b0; cyc(3);
      boton_in[1] = 1'b1; cyc(3); boton_in[1] = 1'b0; clr_overflow = 1'b1;
      cyc(1); clr_overflow = 1'b0;
      chk("clr_coincide", int'(overflow), 4'b0010);

      // button held across reset deassertion
      boton_in[0] = 1'b1; cyc(2);
      reset = 1'b1; cyc(2); reset = 1'b0; cyc(3);
      chk("held_rst_valid", int'(evt_valid), 0); chk("held_rst_ovf", int'(overflow), 0);
      boton_in[0] = 1'b0; cyc(4);
      chk("held_release", int'(evt_valid), 0);

      // reset mid-press with an event waiting at the output
      boton_in[3] = 1'b1; cyc(3); boton_in[3] = 1'b0;
      cyc(2); chk("mid_pre_valid", int'(evt_valid), 1);
      boton_in[0] = 1'b1; cyc(10);
      reset = 1'b1; cyc(1);
      chk("mid_valid", int'(evt_valid), 0); chk("mid_id", int'(evt_id), 0);
      chk("mid_long", int'(evt_long), 0); chk("mid_ovf", int'(overflow), 0);
      reset = 1'b0; cyc(3);
      chk("mid_after_valid", int'(evt_valid), 0);
      boton_in[0] = 1'b0; cyc(4);
      chk("mid_release", int'(evt_valid), 0);
      evt_ready = 1'b1; cyc(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
